// File: rtl/bank_writer3x16.sv
// Three 16-sample register banks filled round-robin from a valid/ready stream and drained in FIFO order.
// Define BANK_WRITER_SATURATE_EN to saturate incoming samples instead of wrapping them.
module bank_writer3x16 #(
    parameter int DATA_WIDTH = 8,
    parameter int IN_EXTRA   = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic wr_valid,
    output logic wr_ready,
    input  logic signed [DATA_WIDTH+IN_EXTRA+1:0] in_0, in_1, in_2, in_3, in_4, in_5, in_6, in_7,
    input  logic signed [DATA_WIDTH+IN_EXTRA+1:0] in_8, in_9, in_10, in_11, in_12, in_13, in_14, in_15,
    output logic rd_valid,
    input  logic rd_ready,
    output logic c1,
    output logic c0,
    output logic signed [DATA_WIDTH+1:0] out_0, out_1, out_2, out_3, out_4, out_5, out_6, out_7,
    output logic signed [DATA_WIDTH+1:0] out_8, out_9, out_10, out_11, out_12, out_13, out_14, out_15,
    output logic signed [DATA_WIDTH+1:0] out_16, out_17, out_18, out_19, out_20, out_21, out_22, out_23,
    output logic signed [DATA_WIDTH+1:0] out_24, out_25, out_26, out_27, out_28, out_29, out_30, out_31,
    output logic signed [DATA_WIDTH+1:0] out_32, out_33, out_34, out_35, out_36, out_37, out_38, out_39,
    output logic signed [DATA_WIDTH+1:0] out_40, out_41, out_42, out_43, out_44, out_45, out_46, out_47,
    output logic [1:0] occupancy
);
    localparam int OW = DATA_WIDTH + 2;
    localparam int IW = OW + IN_EXTRA;

`ifdef BANK_WRITER_SATURATE_EN
    localparam logic signed [IW-1:0] SAT_HI = {{(IN_EXTRA+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [IW-1:0] SAT_LO = {{(IN_EXTRA+1){1'b1}}, {(OW-1){1'b0}}};
`endif

    logic signed [IW-1:0] din [16];
    logic signed [OW-1:0] bank_reg [3][16];
    logic [2:0] full_reg, full_next;
    logic [1:0] wr_bank_reg, wr_bank_next;
    logic [1:0] rd_bank_reg, rd_bank_next;
    logic [1:0] occ_reg, occ_next;
    logic       accept, rel, wr_en;

    assign din[0]  = in_0;  assign din[1]  = in_1;  assign din[2]  = in_2;  assign din[3]  = in_3;
    assign din[4]  = in_4;  assign din[5]  = in_5;  assign din[6]  = in_6;  assign din[7]  = in_7;
    assign din[8]  = in_8;  assign din[9]  = in_9;  assign din[10] = in_10; assign din[11] = in_11;
    assign din[12] = in_12; assign din[13] = in_13; assign din[14] = in_14; assign din[15] = in_15;

    function automatic logic [1:0] advance(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    function automatic logic signed [OW-1:0] conv(input logic signed [IW-1:0] x);
`ifdef BANK_WRITER_SATURATE_EN
        if (x > SAT_HI)
            return SAT_HI[OW-1:0];
        else if (x < SAT_LO)
            return SAT_LO[OW-1:0];
        else
            return x[OW-1:0];
`else
        return x[OW-1:0];
`endif
    endfunction

    // A write and a release can only both fire on different banks, so the two updates never collide.
    always_comb begin
        accept       = wr_valid && !full_reg[wr_bank_reg];
        rel          = rd_ready && full_reg[rd_bank_reg];
        wr_en        = accept && !flush;
        full_next    = full_reg;
        wr_bank_next = wr_bank_reg;
        rd_bank_next = rd_bank_reg;
        if (flush) begin
            full_next    = 3'b000;
            wr_bank_next = 2'd0;
            rd_bank_next = 2'd0;
        end else begin
            if (accept) begin
                full_next[wr_bank_reg] = 1'b1;
                wr_bank_next           = advance(wr_bank_reg);
            end
            if (rel) begin
                full_next[rd_bank_reg] = 1'b0;
                rd_bank_next           = advance(rd_bank_reg);
            end
        end
        occ_next = 2'(full_next[0]) + 2'(full_next[1]) + 2'(full_next[2]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_reg    <= 3'b000;
            wr_bank_reg <= 2'd0;
            rd_bank_reg <= 2'd0;
            occ_reg     <= 2'd0;
        end else begin
            full_reg    <= full_next;
            wr_bank_reg <= wr_bank_next;
            rd_bank_reg <= rd_bank_next;
            occ_reg     <= occ_next;
        end
    end

    // Flush leaves sample contents in place; only the bookkeeping is cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 3; b++)
                for (int k = 0; k < 16; k++)
                    bank_reg[b][k] <= '0;
        end else if (wr_en) begin
            for (int k = 0; k < 16; k++)
                bank_reg[wr_bank_reg][k] <= conv(din[k]);
        end
    end

    assign wr_ready  = !full_reg[wr_bank_reg];
    assign rd_valid  = full_reg[rd_bank_reg];
    assign c1        = (rd_bank_reg != 2'd0);
    assign c0        = (rd_bank_reg == 2'd2);
    assign occupancy = occ_reg;

    assign out_0  = bank_reg[0][0];  assign out_1  = bank_reg[0][1];  assign out_2  = bank_reg[0][2];  assign out_3  = bank_reg[0][3];
    assign out_4  = bank_reg[0][4];  assign out_5  = bank_reg[0][5];  assign out_6  = bank_reg[0][6];  assign out_7  = bank_reg[0][7];
    assign out_8  = bank_reg[0][8];  assign out_9  = bank_reg[0][9];  assign out_10 = bank_reg[0][10]; assign out_11 = bank_reg[0][11];
    assign out_12 = bank_reg[0][12]; assign out_13 = bank_reg[0][13]; assign out_14 = bank_reg[0][14]; assign out_15 = bank_reg[0][15];
    assign out_16 = bank_reg[1][0];  assign out_17 = bank_reg[1][1];  assign out_18 = bank_reg[1][2];  assign out_19 = bank_reg[1][3];
    assign out_20 = bank_reg[1][4];  assign out_21 = bank_reg[1][5];  assign out_22 = bank_reg[1][6];  assign out_23 = bank_reg[1][7];
    assign out_24 = bank_reg[1][8];  assign out_25 = bank_reg[1][9];  assign out_26 = bank_reg[1][10]; assign out_27 = bank_reg[1][11];
    assign out_28 = bank_reg[1][12]; assign out_29 = bank_reg[1][13]; assign out_30 = bank_reg[1][14]; assign out_31 = bank_reg[1][15];
    assign out_32 = bank_reg[2][0];  assign out_33 = bank_reg[2][1];  assign out_34 = bank_reg[2][2];  assign out_35 = bank_reg[2][3];
    assign out_36 = bank_reg[2][4];  assign out_37 = bank_reg[2][5];  assign out_38 = bank_reg[2][6];  assign out_39 = bank_reg[2][7];
    assign out_40 = bank_reg[2][8];  assign out_41 = bank_reg[2][9];  assign out_42 = bank_reg[2][10]; assign out_43 = bank_reg[2][11];
    assign out_44 = bank_reg[2][12]; assign out_45 = bank_reg[2][13]; assign out_46 = bank_reg[2][14]; assign out_47 = bank_reg[2][15];
endmodule

// File: tb/tb_bank_writer3x16.sv
// Randomized bench for bank_writer3x16; the reference model tracks banks as a FIFO of beat counts.
module tb_bank_writer3x16;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, flush, wr_valid, rd_ready;
    logic wr_ready, rd_valid, c1, c0;
    logic [1:0] occupancy;
    logic signed [11:0] in_v [16];
    logic signed [9:0]  out_v [48];

    int checks = 0;
    int errors = 0;
    int mbank [3][16];
    int wr_cnt, rd_cnt;

    bank_writer3x16 dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .in_0(in_v[0]), .in_1(in_v[1]), .in_2(in_v[2]), .in_3(in_v[3]),
        .in_4(in_v[4]), .in_5(in_v[5]), .in_6(in_v[6]), .in_7(in_v[7]),
        .in_8(in_v[8]), .in_9(in_v[9]), .in_10(in_v[10]), .in_11(in_v[11]),
        .in_12(in_v[12]), .in_13(in_v[13]), .in_14(in_v[14]), .in_15(in_v[15]),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .c1(c1), .c0(c0),
        .out_0(out_v[0]), .out_1(out_v[1]), .out_2(out_v[2]), .out_3(out_v[3]),
        .out_4(out_v[4]), .out_5(out_v[5]), .out_6(out_v[6]), .out_7(out_v[7]),
        .out_8(out_v[8]), .out_9(out_v[9]), .out_10(out_v[10]), .out_11(out_v[11]),
        .out_12(out_v[12]), .out_13(out_v[13]), .out_14(out_v[14]), .out_15(out_v[15]),
        .out_16(out_v[16]), .out_17(out_v[17]), .out_18(out_v[18]), .out_19(out_v[19]),
        .out_20(out_v[20]), .out_21(out_v[21]), .out_22(out_v[22]), .out_23(out_v[23]),
        .out_24(out_v[24]), .out_25(out_v[25]), .out_26(out_v[26]), .out_27(out_v[27]),
        .out_28(out_v[28]), .out_29(out_v[29]), .out_30(out_v[30]), .out_31(out_v[31]),
        .out_32(out_v[32]), .out_33(out_v[33]), .out_34(out_v[34]), .out_35(out_v[35]),
        .out_36(out_v[36]), .out_37(out_v[37]), .out_38(out_v[38]), .out_39(out_v[39]),
        .out_40(out_v[40]), .out_41(out_v[41]), .out_42(out_v[42]), .out_43(out_v[43]),
        .out_44(out_v[44]), .out_45(out_v[45]), .out_46(out_v[46]), .out_47(out_v[47]),
        .occupancy(occupancy)
    );

    function automatic int conv_model(int x);
`ifdef BANK_WRITER_SATURATE_EN
        if (x > 511) return 511;
        if (x < -512) return -512;
        return x;
`else
        int v;
        v = x & 1023;
        if (v >= 512) v -= 1024;
        return v;
`endif
    endfunction

    // Bank select code of the oldest full bank, from the count of drained beats.
    function automatic int exp_code();
        case (rd_cnt % 3)
            0: return 0;
            1: return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int exp_occ();
        return wr_cnt - rd_cnt;
    endfunction

    task automatic model_clear();
        wr_cnt = 0;
        rd_cnt = 0;
        for (int b = 0; b < 3; b++)
            for (int k = 0; k < 16; k++)
                mbank[b][k] = 0;
    endtask

    // One clock: decide handshakes from the model, advance, sample #1 after the edge.
    task automatic cycle();
        bit acc, rel;
        acc = wr_valid && (exp_occ() < 3);
        rel = rd_ready && (exp_occ() > 0);
        @(posedge clk);
        #1;
        if (flush) begin
            wr_cnt = 0;
            rd_cnt = 0;
        end else begin
            if (acc) begin
                for (int k = 0; k < 16; k++)
                    mbank[wr_cnt % 3][k] = conv_model(int'(in_v[k]));
                wr_cnt++;
            end
            if (rel) rd_cnt++;
        end
    endtask

    task automatic randomize_inputs();
        for (int k = 0; k < 16; k++)
            in_v[k] = 12'($urandom);
    endtask

    task automatic test_reset();
        int bad;
        rst_n = 1'b0; flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
        for (int k = 0; k < 16; k++) in_v[k] = 12'sd0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (wr_ready !== 1'b1 || rd_valid !== 1'b0 || {c1, c0} !== 2'b00 || occupancy !== 2'd0) begin
            errors++;
            $display("FAIL reset_flags: got wr_ready=%b rd_valid=%b c1c0=%b occ=%0d, want 1 0 00 0",
                     wr_ready, rd_valid, {c1, c0}, occupancy);
        end
        bad = 0;
        for (int i = 0; i < 48; i++) if (out_v[i] !== 10'sd0) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_outs: %0d outputs nonzero, want all 0", bad);
        end
    endtask

    task automatic test_fill();
        int bad;
        wr_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            for (int k = 0; k < 16; k++) in_v[k] = 12'(16 * j + k);
            cycle();
            checks++;
            if (occupancy !== 2'(j + 1)) begin
                errors++;
                $display("FAIL fill_occ[%0d]: got %0d want %0d", j, occupancy, j + 1);
            end
        end
        checks++;
        if (wr_ready !== 1'b0 || rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL fill_full_flags: got wr_ready=%b rd_valid=%b want 0 1", wr_ready, rd_valid);
        end
        for (int k = 0; k < 16; k++) in_v[k] = 12'(-k - 5);
        cycle();
        wr_valid = 1'b0;
        checks++;
        if (occupancy !== 2'd3 || wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_held_beat: got occ=%0d wr_ready=%b want 3 0", occupancy, wr_ready);
        end
        bad = 0;
        for (int i = 0; i < 48; i++) if (out_v[i] !== 10'(i)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL fill_outs: %0d outputs differ from out_i=i", bad);
        end
    endtask

    task automatic test_drain();
        int want_code [3];
        int bad;
        want_code[0] = 0; want_code[1] = 2; want_code[2] = 3;
        rd_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            checks++;
            if ({c1, c0} !== 2'(want_code[j]) || rd_valid !== 1'b1) begin
                errors++;
                $display("FAIL drain_sel[%0d]: got c1c0=%b rd_valid=%b want %0d 1", j, {c1, c0}, rd_valid, want_code[j]);
            end
            cycle();
        end
        rd_ready = 1'b0;
        checks++;
        if (rd_valid !== 1'b0 || occupancy !== 2'd0 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL drain_empty: got rd_valid=%b occ=%0d wr_ready=%b want 0 0 1", rd_valid, occupancy, wr_ready);
        end
        bad = 0;
        for (int i = 0; i < 48; i++) if (out_v[i] !== 10'(i)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL drain_outs_kept: %0d outputs changed", bad);
        end
    endtask

    task automatic test_stream();
        int bad, base;
        wr_valid = 1'b1;
        rd_ready = 1'b1;
        for (int n = 0; n < 9; n++) begin
            randomize_inputs();
            cycle();
            checks++;
            if (occupancy !== 2'(exp_occ()) || occupancy !== 2'd1 || {c1, c0} !== 2'(exp_code())) begin
                errors++;
                $display("FAIL stream[%0d]: got occ=%0d c1c0=%b want 1 %0d", n, occupancy, {c1, c0}, exp_code());
            end
            bad = 0;
            base = 16 * (rd_cnt % 3);
            for (int k = 0; k < 16; k++)
                if (out_v[base + k] !== 10'(mbank[rd_cnt % 3][k])) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL stream_order[%0d]: %0d samples of selected bank wrong", n, bad);
            end
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_flush();
        int bad;
        randomize_inputs();
        cycle();
        checks++;
        if (occupancy !== 2'd2) begin
            errors++;
            $display("FAIL flush_pre_occ: got %0d want 2", occupancy);
        end
        randomize_inputs();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        wr_valid = 1'b0;
        checks++;
        if (occupancy !== 2'd0 || {c1, c0} !== 2'b00 || wr_ready !== 1'b1 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_state: got occ=%0d c1c0=%b wr_ready=%b rd_valid=%b want 0 00 1 0",
                     occupancy, {c1, c0}, wr_ready, rd_valid);
        end
        bad = 0;
        for (int i = 0; i < 48; i++) if (out_v[i] !== 10'(mbank[i / 16][i % 16])) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL flush_no_write: %0d outputs differ from retained contents", bad);
        end
    endtask

    task automatic test_conv();
        int want0, want1;
`ifdef BANK_WRITER_SATURATE_EN
        want0 = 511;  want1 = -512;
`else
        want0 = -424; want1 = 424;
`endif
        randomize_inputs();
        in_v[0] = 12'sd600;
        in_v[1] = -12'sd600;
        wr_valid = 1'b1;
        cycle();
        wr_valid = 1'b0;
        checks++;
        if (int'(out_v[0]) != want0 || int'(out_v[1]) != want1) begin
            errors++;
            $display("FAIL conv: got out_0=%0d out_1=%0d want %0d %0d", out_v[0], out_v[1], want0, want1);
        end
        checks++;
        if (int'(out_v[5]) != mbank[0][5] || occupancy !== 2'd1) begin
            errors++;
            $display("FAIL conv_other: got out_5=%0d occ=%0d want %0d 1", out_v[5], occupancy, mbank[0][5]);
        end
    endtask

    task automatic test_random();
        int bad;
        for (int n = 0; n < 300; n++) begin
            wr_valid = 1'($urandom);
            rd_ready = 1'($urandom);
            flush    = ($urandom_range(0, 31) == 0);
            randomize_inputs();
            cycle();
            checks++;
            if (occupancy !== 2'(exp_occ()) || rd_valid !== (exp_occ() > 0) ||
                wr_ready !== (exp_occ() < 3) || {c1, c0} !== 2'(exp_code())) begin
                errors++;
                $display("FAIL random_ctrl[%0d]: got occ=%0d rd_valid=%b wr_ready=%b c1c0=%b want %0d %0d %0d %0d",
                         n, occupancy, rd_valid, wr_ready, {c1, c0}, exp_occ(), exp_occ() > 0, exp_occ() < 3, exp_code());
            end
            bad = 0;
            for (int i = 0; i < 48; i++) if (out_v[i] !== 10'(mbank[i / 16][i % 16])) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL random_data[%0d]: %0d outputs differ from model", n, bad);
            end
        end
        flush = 1'b0;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int bad;
        wr_valid = 1'b1;
        repeat (2) begin
            randomize_inputs();
            cycle();
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        checks++;
        if (wr_ready !== 1'b1 || rd_valid !== 1'b0 || {c1, c0} !== 2'b00 || occupancy !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid_flags: got wr_ready=%b rd_valid=%b c1c0=%b occ=%0d want 1 0 00 0",
                     wr_ready, rd_valid, {c1, c0}, occupancy);
        end
        bad = 0;
        for (int i = 0; i < 48; i++) if (out_v[i] !== 10'sd0) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_mid_outs: %0d outputs nonzero", bad);
        end
        wr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_stream();
        test_flush();
        test_conv();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
